// File: rtl/modular_multiplier_interleaved.sv
// Bit-serial modular multiplier: out = (a*b) mod P, MSB-first double-and-add.
// One multiplier bit per clock, fixed latency of W clocks.
module modular_multiplier_interleaved #(
   parameter int          W = 256,
   parameter logic [W-1:0] P =
      256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] out,
   output logic         done,
   output logic         busy
);

   localparam int CW = $clog2(W);
   localparam logic [W:0] PX = {1'b0, P};

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [W-1:0]    r_a, r_b, r_acc, r_out;
   logic [CW-1:0]   r_cnt;
   logic            r_done, r_busy;

   logic [W-1:0]    w_a_nxt, w_b_nxt, w_acc_nxt, w_out_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_done_nxt, w_busy_nxt;

   logic            w_bit;
   logic [W:0]      w_dbl, w_dred, w_add;
   logic [W-1:0]    w_s;

   // acc < P holds, so one conditional subtract per step keeps it reduced
   assign w_bit  = r_a[r_cnt];
   assign w_dbl  = {r_acc, 1'b0};
   assign w_dred = (w_dbl >= PX) ? (w_dbl - PX) : w_dbl;
   assign w_add  = w_dred + (w_bit ? {1'b0, r_b} : '0);
   assign w_s    = (w_add >= PX) ? W'(w_add - PX) : w_add[W-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_acc_nxt   = r_acc;
      w_out_nxt   = r_out;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = r_busy;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_a_nxt     = a;
               w_b_nxt     = b;
               w_acc_nxt   = '0;
               w_cnt_nxt   = CW'(W - 1);
               w_busy_nxt  = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_acc_nxt = w_s;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_out_nxt   = w_s;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_out   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_acc   <= w_acc_nxt;
         r_out   <= w_out_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign out  = r_out;
   assign done = r_done;
   assign busy = r_busy;

endmodule

// File: tb/tb_modular_multiplier_interleaved.sv
// Scoreboard bench for modular_multiplier_interleaved.
// Expected products come from a wide (a*b)%P reference model.
module tb_modular_multiplier_interleaved;

   localparam int W = 256;
   localparam logic [W-1:0] P =
      256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
   localparam int LIM = 400;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic [W-1:0] out;
   logic         done, busy;

   int errs   = 0;
   int checks = 0;
   logic [W-1:0] sb[$];

   modular_multiplier_interleaved #(.W(W), .P(P)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .out   (out),
      .done  (done),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      logic [2*W-1:0] pr;
      pr = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      pr = pr % {{W{1'b0}}, P};
      return pr[W-1:0];
   endfunction

   // Drive one start pulse; returns #1 after the accepting edge.
   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      sb.push_back(model(x, y));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n, output bit hit);
      n = 0;
      hit = 1'b0;
      while (n < limit && !hit) begin
         @(posedge clk);
         #1;
         n++;
         hit = done;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      #2;
      checks++;
      if (out !== '0 || done !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reset: out=%h done=%b busy=%b want 0/0/0",
                  out, done, busy);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL idle_after_reset: done=%b busy=%b want 0/0",
                  done, busy);
      end
   endtask

   task automatic test_basic;
      int n;
      bit hit;
      logic [W-1:0] exp;
      launch(256'd2, 256'd3);
      checks++;
      if (busy !== 1'b1) begin
         errs++;
         $display("FAIL busy_rise: got %b want 1", busy);
      end
      wait_done(LIM, n, hit);
      exp = sb.pop_front();
      checks++;
      if (!hit || n != W) begin
         errs++;
         $display("FAIL latency: got %0d (hit=%b) want %0d", n, hit, W);
      end
      checks++;
      if (out !== exp) begin
         errs++;
         $display("FAIL basic_out: got %h want %h", out, exp);
      end
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL busy_in_done: got %b want 0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || out !== exp) begin
         errs++;
         $display("FAIL done_pulse: done=%b out=%h want 0 / %h",
                  done, out, exp);
      end
   endtask

   task automatic test_edges;
      logic [W-1:0] xa[4];
      logic [W-1:0] xb[4];
      int n;
      bit hit;
      logic [W-1:0] exp;
      xa[0] = P - 1;  xb[0] = P - 1;
      xa[1] = P - 1;  xb[1] = 256'd2;
      xa[2] = '1;     xb[2] = 256'd1;
      xa[3] = '0;     xb[3] = P - 1;
      for (int i = 0; i < 4; i++) begin
         launch(xa[i], xb[i]);
         a = '1;
         b = '0;
         wait_done(LIM, n, hit);
         exp = sb.pop_front();
         checks++;
         if (!hit || out !== exp) begin
            errs++;
            $display("FAIL edge%0d: got %h (hit=%b) want %h",
                     i, out, hit, exp);
         end
      end
   endtask

   task automatic test_ignore_start;
      int n;
      int pulses;
      bit hit;
      logic [W-1:0] exp;
      launch(256'd5, 256'd7);
      repeat (99) @(posedge clk);
      @(negedge clk);
      a = 256'd9;
      b = 256'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(LIM, n, hit);
      n += 100;
      exp = sb.pop_front();
      checks++;
      if (!hit || n != W) begin
         errs++;
         $display("FAIL ignore_lat: got %0d (hit=%b) want %0d", n, hit, W);
      end
      checks++;
      if (out !== exp) begin
         errs++;
         $display("FAIL ignore_out: got %h want %h", out, exp);
      end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errs++;
         $display("FAIL ignore_extra: got %0d busy/done cycles want 0",
                  pulses);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      bit hit;
      logic [W-1:0] exp;
      @(negedge clk);
      a = 256'd3;
      b = 256'd4;
      start = 1'b1;
      sb.push_back(model(256'd3, 256'd4));
      @(posedge clk);
      #1;
      a = 256'd6;
      b = 256'd6;
      sb.push_back(model(256'd6, 256'd6));
      wait_done(LIM, n, hit);
      exp = sb.pop_front();
      checks++;
      if (!hit || n != W || out !== exp) begin
         errs++;
         $display("FAIL b2b_first: n=%0d out=%h want %0d / %h",
                  n, out, W, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL b2b_accept: done=%b busy=%b want 0/1", done, busy);
      end
      wait_done(LIM, n, hit);
      start = 1'b0;
      n += W + 1;
      exp = sb.pop_front();
      checks++;
      if (!hit || n != 2 * W + 1) begin
         errs++;
         $display("FAIL b2b_lat: got %0d want %0d", n, 2 * W + 1);
      end
      checks++;
      if (out !== exp) begin
         errs++;
         $display("FAIL b2b_second: got %h want %h", out, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL b2b_stop: done=%b busy=%b want 0/0", done, busy);
      end
   endtask

   task automatic test_reset_midrun;
      int n;
      bit hit;
      logic [W-1:0] exp;
      launch(P - 1, P - 1);
      repeat (127) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      sb.delete();
      checks++;
      if (out !== '0 || done !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL midrun_reset: out=%h done=%b busy=%b want 0/0/0",
                  out, done, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      launch(256'd2, 256'd3);
      wait_done(LIM, n, hit);
      exp = sb.pop_front();
      checks++;
      if (!hit || n != W || out !== exp) begin
         errs++;
         $display("FAIL after_reset: n=%0d out=%h want %0d / %h",
                  n, out, W, exp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_ignore_start();
      test_back_to_back();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
